// File: rtl/mac_result_reader.sv
// mac_result_reader
//   Read-out side of the MAC accumulator. On a start strobe it snapshots the
//   accumulator word into a shadow register. It then streams that copy out over a
//   valid/ready interface, least-significant chunk first. The MAC may keep
//   accumulating while the snapshot drains.
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      one-cycle strobe: capture acc_in and begin read-out (ignored while busy)
//   acc_in     accumulator register value [DATA_W]
//   out_data   current beat [CHUNK_W]
//   out_valid  out_data valid
//   out_ready  downstream accepts the beat when high with out_valid
//   out_last   high with the final beat of a word
//   busy       word captured and not yet fully drained
//   done       one-cycle pulse in the cycle after the final beat is accepted
module mac_result_reader #(
  parameter int DATA_W  = 20,
  parameter int CHUNK_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DATA_W-1:0]  acc_in,
  output logic [CHUNK_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);
  localparam int NCHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]                      state;
  logic [CNT_W-1:0]                cnt;
  logic [NCHUNK-1:0][CHUNK_W-1:0]  shadow;
  logic [NCHUNK*CHUNK_W-1:0]       acc_pad;
  logic                            done_q;
  logic                            is_last;

  // Zero-extend so the unused top bits of the final beat read as 0.
  always_comb begin
    acc_pad = '0;
    acc_pad[DATA_W-1:0] = acc_in;
  end

  assign is_last = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shadow <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shadow <= acc_pad;
            cnt    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          // start is deliberately not looked at here: the word in flight completes.
          if (out_ready) begin
            if (is_last) begin
              state  <= IDLE;
              cnt    <= '0;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs come from state/cnt/shadow only; out_ready never reaches out_valid.
  assign busy      = (state == SEND);
  assign out_valid = (state == SEND);
  assign out_last  = (state == SEND) && is_last;
  assign out_data  = (state == SEND) ? shadow[cnt] : '0;
  assign done      = done_q;

endmodule

// File: tb/tb_mac_result_reader.sv
// Self-checking bench for mac_result_reader: table-driven full-rate words plus
// hand-written stall, ignored-start, chained-start, reset and acc-change sequences.
module tb_mac_result_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [19:0] acc_in = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  mac_result_reader dut (
    .clk(clk), .reset(reset), .start(start), .acc_in(acc_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] acc;
    logic [7:0]  b0, b1, b2;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 32'(out_valid), 32'd0);
    chk({tag, " busy"},  32'(busy),      32'd0);
    chk({tag, " done"},  32'(done),      32'd0);
    chk({tag, " last"},  32'(out_last),  32'd0);
    chk({tag, " data"},  32'(out_data),  32'd0);
  endtask

  // Called at the negedge where start was just driven (ready held 1). Checks three
  // beats on consecutive cycles, then ends at the done-cycle negedge after checking it.
  task automatic drain3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input string tag, input bit scramble);
    logic [7:0] exp_b [3];
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (scramble) acc_in = 20'($urandom);
      chk($sformatf("%s beat%0d data", tag, i), 32'(out_data), 32'(exp_b[i]));
      chk($sformatf("%s beat%0d valid", tag, i), 32'(out_valid), 32'd1);
      chk($sformatf("%s beat%0d busy", tag, i), 32'(busy), 32'd1);
      chk($sformatf("%s beat%0d last", tag, i), 32'(out_last), 32'(i == 2));
      chk($sformatf("%s beat%0d done", tag, i), 32'(done), 32'd0);
    end
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done), 32'd1);
    chk({tag, " busy in done"}, 32'(busy), 32'd0);
    chk({tag, " valid in done"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t vt [5];
    logic [7:0] sb [3];
    bit   pat [6];
    int   idx;

    vt[0] = '{20'hABCDE, 8'hDE, 8'hBC, 8'h0A};
    vt[1] = '{20'hFFFFF, 8'hFF, 8'hFF, 8'h0F};
    vt[2] = '{20'h00000, 8'h00, 8'h00, 8'h00};
    vt[3] = '{20'h12345, 8'h45, 8'h23, 8'h01};
    vt[4] = '{20'h80001, 8'h01, 8'h00, 8'h08};

    // Reset state
    #1;
    chk_idle("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("post-reset");

    // Table: full-rate words, single-cycle done pulse
    for (int v = 0; v < 5; v++) begin
      acc_in = vt[v].acc;
      start  = 1'b1;
      drain3(vt[v].b0, vt[v].b1, vt[v].b2, $sformatf("vec%0d", v), 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d done drop", v), 32'(done), 32'd0);
      chk($sformatf("vec%0d idle valid", v), 32'(out_valid), 32'd0);
    end

    // Stalls: ready 1,0,0,1,0,1 -- beats hold while stalled, exactly 3 transfers
    sb[0] = 8'hDE; sb[1] = 8'hBC; sb[2] = 8'h0A;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1;
    acc_in = 20'hABCDE;
    start  = 1'b1;
    idx    = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("stall c%0d valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall c%0d data", c), 32'(out_data), 32'(sb[idx]));
      chk($sformatf("stall c%0d last", c), 32'(out_last), 32'(idx == 2));
      chk($sformatf("stall c%0d done", c), 32'(done), 32'd0);
      out_ready = pat[c];
      if (pat[c]) idx++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    chk("stall transfers", 32'(idx), 32'd3);
    chk("stall done", 32'(done), 32'd1);
    chk("stall busy", 32'(busy), 32'd0);
    @(negedge clk);

    // start during beat 1 is ignored
    acc_in = 20'hABCDE;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign beat0", 32'(out_data), 32'hDE);
    @(negedge clk);
    chk("ign beat1", 32'(out_data), 32'hBC);
    acc_in = 20'h12345;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign beat2", 32'(out_data), 32'h0A);
    chk("ign busy", 32'(busy), 32'd1);
    chk("ign last", 32'(out_last), 32'd1);
    @(negedge clk);
    chk("ign done", 32'(done), 32'd1);
    @(negedge clk);
    chk("ign no restart", 32'(out_valid), 32'd0);

    // start in the done cycle chains the next word one cycle later
    acc_in = 20'hABCDE;
    start  = 1'b1;
    drain3(8'hDE, 8'hBC, 8'h0A, "chainA", 1'b0);
    acc_in = 20'hFFFFF;
    start  = 1'b1;
    drain3(8'hFF, 8'hFF, 8'h0F, "chainB", 1'b0);
    @(negedge clk);
    chk("chain end done", 32'(done), 32'd0);

    // acc_in changes after capture do not affect the word in flight
    acc_in = 20'h00001;
    start  = 1'b1;
    drain3(8'h01, 8'h00, 8'h00, "accchg", 1'b1);
    @(negedge clk);

    // Reset mid-word: outputs drop immediately, no done afterwards
    acc_in = 20'hABCDE;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst beat0", 32'(out_data), 32'hDE);
    @(negedge clk);
    chk("rst beat1 valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk_idle("rst async");
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_idle($sformatf("rst after c%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
